key_scan_module: RTL and testbench

KEY_SCAN_MODULE -- requirements
Module: key_scan_module

---
 rtl/key_scan_module_pkg.sv | 28 ++
 rtl/key_scan_module_debounce.sv | 75 +++++++
 rtl/key_scan_module.sv | 109 ++++++++++
 tb/tb_key_scan_module.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/key_scan_module_pkg.sv
// Shared 4x4 key-matrix constants and the priority helper used by the scanner.
// Key index layout is row*COLS + col, which is also the emitted key code.
package key_scan_module_pkg;

    localparam int ROWS   = 4;
    localparam int COLS   = 4;
    localparam int KEYS   = ROWS * COLS;
    localparam int CODE_W = 4;
    localparam int ROW_W  = 2;

    localparam logic [ROWS-1:0] ROW_ONE = 4'b0001;

    typedef logic [KEYS-1:0]   key_map_t;
    typedef logic [CODE_W-1:0] key_code_t;

    // Lowest-index set bit; returns 0 for an empty map.
    function automatic key_code_t lowest_set(input key_map_t map);
        key_code_t idx;
        idx = {CODE_W{1'b0}};
        for (int i = KEYS - 1; i >= 0; i--) begin
            if (map[i]) begin
                idx = key_code_t'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/key_scan_module_debounce.sv
// Frame debouncer: requires DEBOUNCE_FRAMES repeats of a frame before it becomes
// the stable map, and reports the lowest newly pressed key of each update.
module key_debounce
    import key_scan_module_pkg::*;
#(
    parameter int DEBOUNCE_FRAMES = 4
) (
    input  logic      clk,
    input  logic      rst,
    input  key_map_t  frame,
    input  logic      frame_done,
    output key_map_t  stable_map,
    output logic      event_valid,
    output key_code_t event_code
);
    localparam int CNT_W = $clog2(DEBOUNCE_FRAMES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DEBOUNCE_FRAMES);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DEBOUNCE_FRAMES - 1);

    key_map_t         prev_r;
    key_map_t         stable_r;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_next_s;
    logic             load_s;
    logic             event_valid_r;
    key_code_t        event_code_r;
    key_map_t         rise_s;

    // Stability counter update; load fires only on the step that reaches saturation.
    always_comb begin
        cnt_next_s = cnt_r;
        load_s     = 1'b0;
        rise_s     = frame & ~stable_r;
        if (frame_done) begin
            if (frame != prev_r) begin
                cnt_next_s = {CNT_W{1'b0}};
            end else if (cnt_r < CNT_MAX) begin
                cnt_next_s = cnt_r + CNT_W'(1);
                load_s     = (cnt_r == CNT_LOAD);
            end else begin
                cnt_next_s = cnt_r;
            end
        end else begin
            cnt_next_s = cnt_r;
        end
    end

    // Frame history, stable map and press-event registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            prev_r        <= {KEYS{1'b0}};
            stable_r      <= {KEYS{1'b0}};
            cnt_r         <= {CNT_W{1'b0}};
            event_valid_r <= 1'b0;
            event_code_r  <= {CODE_W{1'b0}};
        end else begin
            if (frame_done) begin
                prev_r <= frame;
            end
            cnt_r         <= cnt_next_s;
            event_valid_r <= load_s && (|rise_s);
            if (load_s) begin
                stable_r <= frame;
            end
            if (load_s && (|rise_s)) begin
                event_code_r <= lowest_set(rise_s);
            end
        end
    end

    assign stable_map  = stable_r;
    assign event_valid = event_valid_r;
    assign event_code  = event_code_r;

endmodule

// File: rtl/key_scan_module.sv
// 4x4 keypad scanner: row drive, synchronized column sampling into frames,
// debounce via key_debounce, and a one-entry press-event buffer with overflow.
module key_scan_module
    import key_scan_module_pkg::*;
#(
    parameter int SCAN_DIV        = 48000,
    parameter int DEBOUNCE_FRAMES = 4
) (
    input  logic              CLK,
    input  logic              RST,
    output logic [ROWS-1:0]   ROW_OUT,
    input  logic [COLS-1:0]   COL_IN,
    output logic [CODE_W-1:0] key_code,
    output logic              key_valid,
    input  logic              key_ready,
    output logic              key_pressed,
    output logic              overflow
);
    localparam int SLOT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(SCAN_DIV - 1);
    localparam logic [ROW_W-1:0]  ROW_LAST  = ROW_W'(ROWS - 1);

    logic [COLS-1:0]   col_meta_r;
    logic [COLS-1:0]   col_sync_r;
    logic [SLOT_W-1:0] slot_r;
    logic [ROW_W-1:0]  row_r;
    logic [ROW_W-1:0]  row_next_s;
    logic [ROWS-1:0]   row_out_r;
    logic              slot_last_s;
    key_map_t          frame_r;
    logic              frame_done_r;
    key_map_t          stable_map_s;
    logic              event_valid_s;
    key_code_t         event_code_s;
    logic [CODE_W-1:0] key_code_r;
    logic              key_valid_r;
    logic              key_pressed_r;
    logic              overflow_r;

    assign slot_last_s = (slot_r == SLOT_LAST);
    assign row_next_s  = row_r + ROW_W'(1);

    // Column synchronizer, row/slot scan counters and frame assembly.
    // Sampling on the last slot cycle leaves SCAN_DIV-1 cycles for rows and the synchronizer to settle.
    always_ff @(posedge CLK) begin
        if (RST) begin
            col_meta_r   <= {COLS{1'b0}};
            col_sync_r   <= {COLS{1'b0}};
            slot_r       <= {SLOT_W{1'b0}};
            row_r        <= {ROW_W{1'b0}};
            row_out_r    <= 4'b1110;
            frame_r      <= {KEYS{1'b0}};
            frame_done_r <= 1'b0;
        end else begin
            col_meta_r   <= COL_IN;
            col_sync_r   <= col_meta_r;
            frame_done_r <= slot_last_s && (row_r == ROW_LAST);
            if (slot_last_s) begin
                slot_r    <= {SLOT_W{1'b0}};
                row_r     <= row_next_s;
                row_out_r <= ~(ROW_ONE << row_next_s);
                frame_r[int'(row_r) * COLS +: COLS] <= ~col_sync_r;
            end else begin
                slot_r <= slot_r + SLOT_W'(1);
            end
        end
    end

    key_debounce #(
        .DEBOUNCE_FRAMES (DEBOUNCE_FRAMES)
    ) u_debounce (
        .clk         (CLK),
        .rst         (RST),
        .frame       (frame_r),
        .frame_done  (frame_done_r),
        .stable_map  (stable_map_s),
        .event_valid (event_valid_s),
        .event_code  (event_code_s)
    );

    // One-entry event buffer: a consumed slot may be refilled in the same cycle.
    always_ff @(posedge CLK) begin
        if (RST) begin
            key_code_r    <= {CODE_W{1'b0}};
            key_valid_r   <= 1'b0;
            key_pressed_r <= 1'b0;
            overflow_r    <= 1'b0;
        end else begin
            key_pressed_r <= |stable_map_s;
            if (event_valid_s) begin
                if (!key_valid_r || key_ready) begin
                    key_code_r  <= event_code_s;
                    key_valid_r <= 1'b1;
                end else begin
                    overflow_r <= 1'b1;
                end
            end else if (key_valid_r && key_ready) begin
                key_valid_r <= 1'b0;
            end
        end
    end

    assign ROW_OUT     = row_out_r;
    assign key_code    = key_code_r;
    assign key_valid   = key_valid_r;
    assign key_pressed = key_pressed_r;
    assign overflow    = overflow_r;

endmodule

// File: tb/tb_key_scan_module.sv
// Directed bench for key_scan_module with SCAN_DIV=4, DEBOUNCE_FRAMES=2 (16-cycle frames).
// A behavioural keypad model pulls columns low for pressed keys on the driven row.
module tb_key_scan_module;

    logic        clk;
    logic        rst;
    logic [3:0]  row_out;
    logic [3:0]  col_in;
    logic [3:0]  key_code;
    logic        key_valid;
    logic        key_ready;
    logic        key_pressed;
    logic        overflow;
    logic [15:0] keys;

    int n_cmp;
    int n_err;
    int ev_cnt;
    int lat;

    key_scan_module #(
        .SCAN_DIV        (4),
        .DEBOUNCE_FRAMES (2)
    ) dut (
        .CLK         (clk),
        .RST         (rst),
        .ROW_OUT     (row_out),
        .COL_IN      (col_in),
        .key_code    (key_code),
        .key_valid   (key_valid),
        .key_ready   (key_ready),
        .key_pressed (key_pressed),
        .overflow    (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        col_in = 4'b1111;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (!row_out[r] && keys[r * 4 + c]) begin
                    col_in[c] = 1'b0;
                end
            end
        end
    end

    // Count consumed events (handshakes) seen mid-cycle.
    always @(negedge clk) begin
        if (!rst && key_valid && key_ready) begin
            ev_cnt++;
        end
    end

    initial begin
        #300000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_frames(input int n);
        repeat (n * 16) tick();
    endtask

    // Return just after the edge that starts row 0 of a new frame.
    task automatic align();
        int n;
        n = 0;
        while (row_out !== 4'b0111 && n < 40) begin
            tick();
            n++;
        end
        while (row_out !== 4'b1110 && n < 80) begin
            tick();
            n++;
        end
        chk("align_frame", {15'd0, (n < 80)}, 16'd1);
    endtask

    task automatic wait_valid(output int cycles);
        cycles = 0;
        while (!key_valid && cycles < 200) begin
            tick();
            cycles++;
        end
        chk("valid_seen", {15'd0, key_valid}, 16'd1);
    endtask

    initial begin
        n_cmp     = 0;
        n_err     = 0;
        ev_cnt    = 0;
        keys      = 16'd0;
        key_ready = 1'b1;
        rst       = 1'b1;
        repeat (3) tick();
        chk("rst_row_out", {12'd0, row_out}, 16'h000e);
        chk("rst_key_code", {12'd0, key_code}, 16'd0);
        chk("rst_flags", {13'd0, key_valid, key_pressed, overflow}, 16'd0);

        // Idle scan: each row held for 4 cycles.
        rst = 1'b0;
        for (int k = 0; k < 16; k++) begin
            logic [3:0] one;
            one = 4'b0001;
            if (k > 0) tick();
            chk("idle_row_out", {12'd0, row_out}, {12'd0, ~(one << (k / 4))});
            chk("idle_flags", {13'd0, key_valid, key_pressed, overflow}, 16'd0);
        end

        // Hold key 6: one event after three identical frames.
        align();
        keys = 16'h0040;
        wait_valid(lat);
        chk("k6_latency", lat[15:0], 16'd50);
        chk("k6_code", {12'd0, key_code}, 16'd6);
        chk("k6_pressed", {15'd0, key_pressed}, 16'd1);
        tick();
        chk("k6_valid_clear", {15'd0, key_valid}, 16'd0);
        wait_frames(4);
        chk("k6_single_event", ev_cnt[15:0], 16'd1);
        chk("k6_still_pressed", {15'd0, key_pressed}, 16'd1);
        keys = 16'd0;
        wait_frames(5);
        chk("k6_release_pressed", {15'd0, key_pressed}, 16'd0);
        chk("k6_release_no_event", ev_cnt[15:0], 16'd1);

        // Key 9 bouncing every frame, then held.
        align();
        for (int i = 0; i < 6; i++) begin
            keys = (i % 2 == 0) ? 16'h0200 : 16'h0000;
            wait_frames(1);
        end
        chk("k9_bounce_no_event", ev_cnt[15:0], 16'd1);
        chk("k9_bounce_valid", {15'd0, key_valid}, 16'd0);
        chk("k9_bounce_pressed", {15'd0, key_pressed}, 16'd0);
        keys = 16'h0200;
        wait_valid(lat);
        chk("k9_latency", lat[15:0], 16'd50);
        chk("k9_code", {12'd0, key_code}, 16'd9);
        wait_frames(4);
        chk("k9_single_event", ev_cnt[15:0], 16'd2);
        keys = 16'd0;
        wait_frames(5);

        // Keys 3 and 12 together: lowest index wins, no overflow.
        align();
        keys = 16'h1008;
        wait_valid(lat);
        chk("k3_12_code", {12'd0, key_code}, 16'd3);
        wait_frames(4);
        chk("k3_12_single_event", ev_cnt[15:0], 16'd3);
        chk("k3_12_overflow", {15'd0, overflow}, 16'd0);
        chk("k3_12_pressed", {15'd0, key_pressed}, 16'd1);
        keys = 16'd0;
        wait_frames(5);

        // Consumer stalled: second press is lost and flagged.
        key_ready = 1'b0;
        align();
        keys = 16'h0002;
        wait_valid(lat);
        chk("k1_code", {12'd0, key_code}, 16'd1);
        keys = 16'd0;
        wait_frames(5);
        chk("k1_release_valid", {15'd0, key_valid}, 16'd1);
        chk("k1_release_overflow", {15'd0, overflow}, 16'd0);
        align();
        keys = 16'h0020;
        wait_frames(4);
        chk("k5_drop_code", {12'd0, key_code}, 16'd1);
        chk("k5_drop_valid", {15'd0, key_valid}, 16'd1);
        chk("k5_drop_overflow", {15'd0, overflow}, 16'd1);
        key_ready = 1'b1;
        tick();
        chk("k1_accept_clear", {15'd0, key_valid}, 16'd0);
        chk("k1_accept_count", ev_cnt[15:0], 16'd4);
        keys = 16'd0;
        wait_frames(5);
        chk("overflow_sticky", {15'd0, overflow}, 16'd1);

        // Reset during row 2 with an event pending, key held throughout.
        key_ready = 1'b0;
        align();
        keys = 16'h0080;
        wait_valid(lat);
        chk("k7_code", {12'd0, key_code}, 16'd7);
        lat = 0;
        while (row_out !== 4'b1011 && lat < 40) begin
            tick();
            lat++;
        end
        chk("k7_row2", {12'd0, row_out}, 16'h000b);
        rst = 1'b1;
        tick();
        chk("mid_rst_row_out", {12'd0, row_out}, 16'h000e);
        chk("mid_rst_key_code", {12'd0, key_code}, 16'd0);
        chk("mid_rst_flags", {13'd0, key_valid, key_pressed, overflow}, 16'd0);
        rst = 1'b0;
        key_ready = 1'b1;
        wait_valid(lat);
        chk("k7_redebounce_latency", lat[15:0], 16'd50);
        chk("k7_redebounce_code", {12'd0, key_code}, 16'd7);
        wait_frames(4);
        chk("k7_single_event", ev_cnt[15:0], 16'd5);
        keys = 16'd0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
